alu_issue_stage: RTL and testbench

// - Upstream feeder for the execute-stage ALU. Buffers ALU requests in a FIFO and drives the

---
 rtl/riscv_alu_pkg.sv | 23 ++
 rtl/alu_issue_stage_if.sv | 56 +++++
 rtl/alu_req_fifo.sv | 61 ++++++
 rtl/alu_issue_stage.sv | 106 ++++++++++
 tb/tb_alu_issue_stage.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared types and constants for the ALU issue stage: the buffered request
// record and the ALU opcode encodings used when generating stimulus.
package riscv_alu_pkg;

  // Width of the opaque request tag carried alongside each op.
  localparam int ALU_TAG_W = 5;

  // ALU opcodes. The issue stage passes these through without interpreting them.
  localparam logic [2:0] ALUCTRL_ADD = 3'b000;
  localparam logic [2:0] ALUCTRL_SUB = 3'b001;
  localparam logic [2:0] ALUCTRL_AND = 3'b010;
  localparam logic [2:0] ALUCTRL_OR  = 3'b011;
  localparam logic [2:0] ALUCTRL_SLT = 3'b101;

  // One buffered ALU request.
  typedef struct packed {
    logic [31:0]          srca;
    logic [31:0]          srcb;
    logic [2:0]           aluctrl;
    logic [ALU_TAG_W-1:0] tag;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the request handshake, the ALU drive/return wires and the
// response handshake of the ALU issue stage.
//
// Handshake rule (request and response channels alike): a transfer happens
// on a rising clk edge where valid and ready are both 1. The sender holds
// valid and its payload until that edge; ready may be computed from the
// receiver's registered state only, never from valid.
interface alu_issue_stage_if
  import riscv_alu_pkg::*;
#(
  parameter int TAG_W = ALU_TAG_W
);

  // Request channel (decode/operand fetch -> issue stage)
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_srca;
  logic [31:0]      req_srcb;
  logic [2:0]       req_aluctrl;
  logic [TAG_W-1:0] req_tag;

  // ALU drive and combinational return
  logic [31:0]      SrcA;
  logic [31:0]      SrcB;
  logic [2:0]       ALUControl;
  logic [31:0]      ALUResult;
  logic             Zero;

  // Response channel (issue stage -> writeback/branch logic)
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;

  // The issue stage itself.
  modport slave (
    input  req_valid, req_srca, req_srcb, req_aluctrl, req_tag,
    output req_ready,
    output SrcA, SrcB, ALUControl,
    input  ALUResult, Zero,
    output rsp_valid, rsp_result, rsp_zero, rsp_tag,
    input  rsp_ready
  );

  // The surroundings: producer, ALU and consumer.
  modport master (
    output req_valid, req_srca, req_srcb, req_aluctrl, req_tag,
    input  req_ready,
    input  SrcA, SrcB, ALUControl,
    output ALUResult, Zero,
    input  rsp_valid, rsp_result, rsp_zero, rsp_tag,
    output rsp_ready
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Request FIFO for the ALU issue stage. Occupancy is tracked by an explicit
// counter, so full/empty never depend on pointer comparison. The caller must
// not push when full nor pop when empty.
module alu_req_fifo
  import riscv_alu_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers ALU requests, drives the FIFO head onto the ALU
// inputs and captures the ALU's combinational result into a registered
// response slot with valid/ready backpressure. One op per cycle sustained.
// TAG_W must equal riscv_alu_pkg::ALU_TAG_W, the tag width of the buffered record.
module alu_issue_stage
  import riscv_alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  alu_issue_stage_if.slave       bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            op_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  alu_req_t         push_req;
  alu_req_t         head;
  logic             empty;
  logic             full;
  logic             push;
  logic             cap;

  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic             rsp_zero_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never opens req_ready.
  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == CNT_W'(DEPTH));

  assign bus.req_ready = !full && !flush;
  assign push          = bus.req_valid && bus.req_ready;

  // Capture the head whenever the response slot is free or being drained.
  assign cap = !empty && (!rsp_valid_q || bus.rsp_ready) && !flush;

  // Pack the incoming request into the buffered record.
  always_comb begin
    push_req         = '0;
    push_req.srca    = bus.req_srca;
    push_req.srcb    = bus.req_srcb;
    push_req.aluctrl = bus.req_aluctrl;
    push_req.tag     = bus.req_tag;
  end

  alu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_req_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .din   (push_req),
    .pop   (cap),
    .head  (head),
    .count (fifo_count)
  );

  // ALU drive: head entry when buffered, otherwise a clean all-zero op.
  always_comb begin
    bus.SrcA       = '0;
    bus.SrcB       = '0;
    bus.ALUControl = '0;
    if (!empty) begin
      bus.SrcA       = head.srca;
      bus.SrcB       = head.srcb;
      bus.ALUControl = head.aluctrl;
    end
  end

  // Response slot and completion counter; flush drops the valid but keeps
  // the last captured payload and the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
      op_count     <= '0;
    end else if (flush) begin
      rsp_valid_q <= 1'b0;
    end else if (cap) begin
      rsp_valid_q  <= 1'b1;
      rsp_result_q <= bus.ALUResult;
      rsp_zero_q   <= bus.Zero;
      rsp_tag_q    <= head.tag;
      op_count     <= op_count + 32'd1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU closes the SrcA/SrcB ->
// ALUResult loop, a queue-based model tracks buffered requests and the
// response slot, and an expected-response queue checks ordering.
module tb_alu_issue_stage;
  import riscv_alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = ALU_TAG_W;
  localparam int W     = 32 + 1 + TAG_W;

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [31:0]            op_count;

  alu_issue_stage_if #(.TAG_W(TAG_W)) bus ();

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .fifo_count (fifo_count),
    .op_count   (op_count)
  );

  // ---------------- ALU behaviour ----------------
  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      ALUCTRL_ADD: return a + b;
      ALUCTRL_SUB: return a - b;
      ALUCTRL_AND: return a & b;
      ALUCTRL_OR:  return a | b;
      ALUCTRL_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:     return 32'd0;
    endcase
  endfunction

  assign bus.ALUResult = alu_ref(bus.ALUControl, bus.SrcA, bus.SrcB);
  assign bus.Zero      = (bus.ALUResult == 32'd0);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  alu_req_t         m_q[$];
  logic             m_rv;
  logic [31:0]      m_res;
  logic             m_zero;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_ops;
  logic [W-1:0]     exp_q[$];
  logic [2:0]       ops_tbl [5];
  int               checks;
  int               errors;

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_rv   = 1'b0;
    m_res  = '0;
    m_zero = 1'b0;
    m_tag  = '0;
    m_ops  = '0;
  endtask

  // Drive one cycle (from just after an edge to just after the next one)
  // and advance the model by that edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c, input logic [TAG_W-1:0] t,
                      input logic rr, input logic fl);
    alu_req_t     req;
    logic [31:0]  r;
    logic         acc;
    logic         take;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    bus.req_valid   = v;
    bus.req_srca    = a;
    bus.req_srcb    = b;
    bus.req_aluctrl = c;
    bus.req_tag     = t;
    bus.rsp_ready   = rr;
    flush           = fl;
    #1;
    req  = '{srca: a, srcb: b, aluctrl: c, tag: t};
    acc  = v && (m_q.size() < DEPTH) && !fl;
    take = (m_q.size() != 0) && (!m_rv || rr) && !fl;
    // consumer-side handshake: the delivered response must be the oldest expected one
    if (bus.rsp_valid && rr) begin
      got = {bus.rsp_result, bus.rsp_zero, bus.rsp_tag};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: delivered %h, nothing expected", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_order: delivered %h, expected %h", got, exp);
        end
      end
    end
    if (fl) begin
      m_q.delete();
      exp_q.delete();
      m_rv = 1'b0;
    end else begin
      if (take) begin
        r      = alu_ref(m_q[0].aluctrl, m_q[0].srca, m_q[0].srcb);
        m_res  = r;
        m_zero = (r == 32'd0);
        m_tag  = m_q[0].tag;
        m_rv   = 1'b1;
        void'(m_q.pop_front());
        m_ops  = m_ops + 32'd1;
      end else if (m_rv && rr) begin
        m_rv = 1'b0;
      end
      if (acc) begin
        m_q.push_back(req);
        r = alu_ref(c, a, b);
        exp_q.push_back({r, (r == 32'd0), t});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_rsp: got %b/%h/%b/%h, want all zero", bus.rsp_valid,
               bus.rsp_result, bus.rsp_zero, bus.rsp_tag);
    end
    checks++;
    if (fifo_count !== '0 || op_count !== '0) begin
      errors++;
      $display("FAIL reset_counts: fifo_count=%0d op_count=%0d, want 0/0", fifo_count, op_count);
    end
    checks++;
    if ({bus.SrcA, bus.SrcB, bus.ALUControl} !== '0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_drive: SrcA=%h SrcB=%h ctrl=%b req_ready=%b, want 0/0/0/1",
               bus.SrcA, bus.SrcB, bus.ALUControl, bus.req_ready);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single_op();
    bus.req_valid   = 1'b1;
    bus.req_srca    = 32'd5;
    bus.req_srcb    = 32'd7;
    bus.req_aluctrl = ALUCTRL_ADD;
    bus.req_tag     = TAG_W'(3);
    bus.rsp_ready   = 1'b1;
    #1;
    checks++;
    if ({bus.SrcA, bus.SrcB, bus.ALUControl} !== '0) begin
      errors++;
      $display("FAIL no_bypass: SrcA=%h SrcB=%h ctrl=%b, want zeros", bus.SrcA, bus.SrcB,
               bus.ALUControl);
    end
    step(1'b1, 32'd5, 32'd7, ALUCTRL_ADD, TAG_W'(3), 1'b1, 1'b0);
    checks++;
    if (fifo_count !== 3'd1 || bus.SrcA !== 32'd5 || bus.SrcB !== 32'd7 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_head: count=%0d SrcA=%0d SrcB=%0d rsp_valid=%b, want 1/5/7/0",
               fifo_count, bus.SrcA, bus.SrcB, bus.rsp_valid);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_tag !== TAG_W'(3) || op_count !== 32'd1) begin
      errors++;
      $display("FAIL single_rsp: valid=%b result=%0d zero=%b tag=%0d ops=%0d, want 1/12/0/3/1",
               bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag, op_count);
    end
    checks++;
    if (fifo_count !== 3'd0 || bus.SrcA !== 32'd0) begin
      errors++;
      $display("FAIL single_empty_drive: count=%0d SrcA=%h, want 0/0", fifo_count, bus.SrcA);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'd12) begin
      errors++;
      $display("FAIL single_drain: valid=%b result=%0d, want 0/12", bus.rsp_valid, bus.rsp_result);
    end
  endtask

  task automatic test_zero_flag();
    step(1'b1, 32'd9, 32'd9, ALUCTRL_SUB, TAG_W'(4), 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL zero_sub: valid=%b result=%0d zero=%b, want 1/0/1", bus.rsp_valid,
               bus.rsp_result, bus.rsp_zero);
    end
    step(1'b1, 32'd5, 32'd7, ALUCTRL_SLT, TAG_W'(6), 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd1 || bus.rsp_zero !== 1'b0 ||
        bus.rsp_tag !== TAG_W'(6)) begin
      errors++;
      $display("FAIL zero_slt: valid=%b result=%0d zero=%b tag=%0d, want 1/1/0/6", bus.rsp_valid,
               bus.rsp_result, bus.rsp_zero, bus.rsp_tag);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, $urandom, ops_tbl[$urandom_range(0, 4)], TAG_W'(10 + i), 1'b0, 1'b0);
    end
    checks++;
    if (fifo_count !== 3'd4 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 ||
        bus.rsp_tag !== TAG_W'(10)) begin
      errors++;
      $display("FAIL bp_full: count=%0d req_ready=%b valid=%b tag=%0d, want 4/0/1/10",
               fifo_count, bus.req_ready, bus.rsp_valid, bus.rsp_tag);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b0, 1'b0);
      checks++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_zero, bus.rsp_tag} !== {m_res, m_zero, m_tag} ||
          bus.rsp_tag !== TAG_W'(10) || fifo_count !== 3'd4) begin
        errors++;
        $display("FAIL bp_stall: cycle %0d valid=%b rsp=%h/%b/%0d count=%0d, want 1/%h/%b/10 count 4",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag, fifo_count,
                 m_res, m_zero);
      end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== TAG_W'(10 + i)) begin
        errors++;
        $display("FAIL bp_drain: slot %0d valid=%b tag=%0d, want 1/%0d", i, bus.rsp_valid,
                 bus.rsp_tag, 10 + i);
      end
      if (i == 0) begin
        bus.req_valid = 1'b1;
        bus.req_tag   = TAG_W'(15);
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_pop: req_ready=%b while full and popping, want 0", bus.req_ready);
        end
        step(1'b1, 32'd1, 32'd1, ALUCTRL_ADD, TAG_W'(15), 1'b1, 1'b0);
      end else begin
        step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
      end
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || fifo_count !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_end: valid=%b count=%0d pending=%0d, want 0/0/0", bus.rsp_valid,
               fifo_count, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base;
    logic        want_v;
    base = m_ops;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        step(1'b1, $urandom, $urandom, ops_tbl[$urandom_range(0, 4)], TAG_W'(k), 1'b1, 1'b0);
      end else begin
        step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
      end
      want_v = (k >= 1) && (k <= 16);
      checks++;
      if (bus.rsp_valid !== want_v || (want_v && bus.rsp_tag !== TAG_W'(k - 1)) ||
          fifo_count !== ((k < 16) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL stream: step %0d valid=%b tag=%0d count=%0d, want valid=%b tag=%0d",
                 k, bus.rsp_valid, bus.rsp_tag, fifo_count, want_v, k - 1);
      end
    end
    checks++;
    if (op_count !== base + 32'd16) begin
      errors++;
      $display("FAIL stream_ops: op_count=%0d, want %0d", op_count, base + 32'd16);
    end
  endtask

  task automatic test_flush();
    logic [31:0] saved_ops;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'd100 + i, 32'd1, ALUCTRL_ADD, TAG_W'(20 + i), 1'b0, 1'b0);
    end
    checks++;
    if (fifo_count !== 3'd3 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_setup: count=%0d valid=%b, want 3/1", fifo_count, bus.rsp_valid);
    end
    saved_ops = m_ops;
    step(1'b1, 32'd1, 32'd2, ALUCTRL_ADD, TAG_W'(24), 1'b0, 1'b1);
    checks++;
    if (fifo_count !== 3'd0 || bus.rsp_valid !== 1'b0 || bus.SrcA !== 32'd0 ||
        op_count !== saved_ops || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b SrcA=%h ops=%0d req_ready=%b, want 0/0/0/%0d/0",
               fifo_count, bus.rsp_valid, bus.SrcA, op_count, bus.req_ready, saved_ops);
    end
    checks++;
    if (bus.rsp_tag !== TAG_W'(20) || bus.rsp_result !== 32'd101) begin
      errors++;
      $display("FAIL flush_hold: tag=%0d result=%0d, want 20/101", bus.rsp_tag, bus.rsp_result);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    step(1'b1, 32'd3, 32'd4, ALUCTRL_ADD, TAG_W'(25), 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== TAG_W'(25) || bus.rsp_result !== 32'd7) begin
      errors++;
      $display("FAIL flush_after: valid=%b tag=%0d result=%0d, want 1/25/7", bus.rsp_valid,
               bus.rsp_tag, bus.rsp_result);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] hs;
    logic [31:0] hb;
    logic [2:0]  hc;
    logic        fl;
    for (int n = 0; n < 300; n++) begin
      fl = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 9) < 7, $urandom, $urandom, 3'($urandom_range(0, 7)),
           TAG_W'($urandom_range(0, 31)), $urandom_range(0, 9) < 6, fl);
      hs = (m_q.size() != 0) ? m_q[0].srca : 32'd0;
      hb = (m_q.size() != 0) ? m_q[0].srcb : 32'd0;
      hc = (m_q.size() != 0) ? m_q[0].aluctrl : 3'd0;
      checks++;
      if (fifo_count !== 3'(m_q.size()) || bus.req_ready !== ((m_q.size() < DEPTH) && !fl)) begin
        errors++;
        $display("FAIL rand_fifo: cycle %0d count=%0d req_ready=%b, want %0d/%b", n, fifo_count,
                 bus.req_ready, m_q.size(), (m_q.size() < DEPTH) && !fl);
      end
      checks++;
      if ({bus.SrcA, bus.SrcB, bus.ALUControl} !== {hs, hb, hc}) begin
        errors++;
        $display("FAIL rand_drive: cycle %0d got %h/%h/%b, want %h/%h/%b", n, bus.SrcA, bus.SrcB,
                 bus.ALUControl, hs, hb, hc);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag} !== {m_rv, m_res, m_zero, m_tag} ||
          op_count !== m_ops) begin
        errors++;
        $display("FAIL rand_rsp: cycle %0d got %b/%h/%b/%0d ops=%0d, want %b/%h/%b/%0d ops=%0d", n,
                 bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag, op_count,
                 m_rv, m_res, m_zero, m_tag, m_ops);
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (exp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: pending=%0d valid=%b, want 0/0", exp_q.size(), bus.rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'd1 + k, 32'd100, ALUCTRL_ADD, TAG_W'(k + 1), 1'b1, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    flush         = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_tag} !== '0 ||
        fifo_count !== '0 || op_count !== '0 || bus.SrcA !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b result=%h tag=%0d count=%0d ops=%0d SrcA=%h, want zeros",
               bus.rsp_valid, bus.rsp_result, bus.rsp_tag, fifo_count, op_count, bus.SrcA);
    end
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 32'd5, 32'd7, ALUCTRL_ADD, TAG_W'(3), 1'b1, 1'b0);
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd12 || bus.rsp_tag !== TAG_W'(3) ||
        op_count !== 32'd1) begin
      errors++;
      $display("FAIL async_recover: valid=%b result=%0d tag=%0d ops=%0d, want 1/12/3/1",
               bus.rsp_valid, bus.rsp_result, bus.rsp_tag, op_count);
    end
    step(1'b0, 32'd0, 32'd0, 3'd0, '0, 1'b1, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks          = 0;
    errors          = 0;
    ops_tbl[0]      = ALUCTRL_ADD;
    ops_tbl[1]      = ALUCTRL_SUB;
    ops_tbl[2]      = ALUCTRL_AND;
    ops_tbl[3]      = ALUCTRL_OR;
    ops_tbl[4]      = ALUCTRL_SLT;
    reset           = 1'b1;
    flush           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_srca    = '0;
    bus.req_srcb    = '0;
    bus.req_aluctrl = '0;
    bus.req_tag     = '0;
    bus.rsp_ready   = 1'b0;
    model_reset();

    test_reset();
    test_single_op();
    test_zero_flag();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_pending: %0d responses never delivered, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
